sprite_line_fetch: RTL and testbench
====================================

Name: sprite_line_fetch

Overview:
- Sequences the single synchronous image ROM: during each horizontal blanking interval it fetches the next scan line's sprite row into an internal line buffer.
- During active video it overlays the buffered pixels on the incoming background stream.
- Sits in the VGA pipeline after the timing/background stages. It replaces per-pixel ROM lookups, so the downstream multi-stage realignment is no longer needed for sprites.

Parameters:
SPRITE_W, 64, sprite width in pixels (power of two)
SPRITE_H, 64, sprite height in lines
ROM_LAT, 2, ROM read latency in pclk cycles (address to data)
ADDR_W, 12, ROM address width, equal to log2(SPRITE_W*SPRITE_H)
V_TOTAL, 628, total lines per frame, used for vcount wrap
TRANSPARENT, 12'h000, pixel value treated as see-through

Ports:
pclk  in  1  pixel clock
rst  in  1  reset
hcount_in  in  11  horizontal pixel counter
vcount_in  in  11  vertical line counter
hblnk_in  in  1  horizontal blank
vblnk_in  in  1  vertical blank
hs_in  in  1  hsync
vs_in  in  1  vsync
rgb_in  in  12  background pixel
xpos  in  12  sprite left column
ypos  in  12  sprite top line
rom_addr  out  ADDR_W  image ROM address (registered)
rom_data  in  12  image ROM data, valid ROM_LAT cycles after rom_addr
hcount, vcount  out  11 each  delayed counters
hblnk, vblnk, hs_out, vs_out  out  1 each  delayed timing
rgb_out  out  12  composited pixel
busy  out  1  fetch in progress
overrun  out  1  one-cycle pulse when a fetch is aborted

Behaviour:
Reset and clocking:
- Reset rst, synchronous, active-high; clock pclk.
- On rst: all outputs 0, FSM goes to IDLE, line_valid=0, x_lat=0, y_lat=0.
- Asserting rst mid-fetch aborts the fetch with no overrun pulse.

Position latching:
- On a vblnk_in rising edge (vblnk_in=1, previous sample 0), latch x_lat<=xpos and y_lat<=ypos.
- A position change therefore takes effect only on the next frame.

Fetch start:
- On an hblnk_in rising edge, compute next = (vcount_in==V_TOTAL-1) ? 0 : vcount_in+1, in 12-bit arithmetic.
- If y_lat <= next < y_lat+SPRITE_H: row = next-y_lat, go to FETCH, line_valid<=0.
- Otherwise line_valid<=0 and the FSM stays in or returns to IDLE.
- All comparisons are 13-bit so that y_lat+SPRITE_H cannot wrap.

FSM states:
- IDLE: wait for an hblnk rising edge.
- FETCH: issue one address per cycle, rom_addr = row*SPRITE_W + col for col = 0..SPRITE_W-1, then go to DRAIN.
- DRAIN: wait ROM_LAT cycles for the last data word, then go to READY.
- READY: set line_valid=1; the next hblnk rising edge restarts the sequence.

Data capture and overrun:
- The write-enable and col index are delayed ROM_LAT cycles alongside the ROM; buffer[col_d] <= rom_data.
- busy = 1 in FETCH and DRAIN.
- If hblnk_in falls while in FETCH or DRAIN: pulse overrun for one cycle, go to IDLE, line_valid=0. The line is then shown as background only.

Display path (latency exactly 1 cycle):
- hcount, vcount, hblnk, vblnk, hs_out and vs_out are the inputs registered once.
- rgb_out <= buf[hcount_in - x_lat] when all of the following hold; otherwise rgb_in:
  - line_valid=1;
  - !hblnk_in && !vblnk_in;
  - x_lat <= hcount_in < x_lat+SPRITE_W (13-bit compare);
  - the pixel != TRANSPARENT.
- The buffer read is combinational.
- Pixels past the visible edge are clipped by the blank signals; there is no horizontal wrap.

Buffer hazard:
- The buffer is single-banked. Writes occur only during hblank, after the previous line's reads are complete, so there is no read/write conflict.

Decomposition:
- Shared package vga_pkg holds:
  - RGB width 12 and counter width 11;
  - H/V timing constants including V_TOTAL;
  - TRANSPARENT colour;
  - the FSM state enum (IDLE, FETCH, DRAIN, READY).
- One sub-module, sprite_line_buffer: SPRITE_W x 12 distributed RAM, synchronous write, asynchronous read.

Test Plan:
1. Reset: hold rst 5 cycles mid-line -> all outputs 0, busy=0. After release, outputs track the inputs with 1-cycle delay.
2. Overlay window: xpos=100, ypos=50, ROM model data = addr[11:0]; run a frame.
   - During line 49 hblank: rom_addr sweeps 0..63.
   - On line 50: rgb_out at hcount 100..163 equals 0..63 (except col 0, since 0 = TRANSPARENT).
   - hcount 99 and 164 show rgb_in.
3. Transparency: ROM returns 12'h000 at col 5 -> rgb_out at hcount x_lat+5 equals rgb_in.
4. Outside range: ypos=300 -> no fetch on lines 0..298 (busy=0, rom_addr constant), sprite drawn on lines 300..363, line 364 is background.
5. Mid-frame position change: move xpos 100->200 at line 200 -> lines 200+ still use 100; the next frame uses 200.
6. Overrun: shorten hblank to 30 cycles -> overrun pulses once per sprite line, line_valid=0, sprite lines show rgb_in only.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA pipeline definitions: data widths, timing constants, the
// see-through colour and the sprite fetch FSM encoding.
package vga_pkg;

  localparam int RGB_W = 12;
  localparam int CNT_W = 11;

  localparam int H_ACTIVE      = 800;
  localparam int H_TOTAL       = 1056;
  localparam int V_ACTIVE      = 600;
  localparam int V_TOTAL_LINES = 628;

  localparam logic [RGB_W-1:0] TRANSPARENT_RGB = 12'h000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    READY = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/sprite_line_buffer.sv
// One sprite row of pixels: synchronous write from the ROM side,
// asynchronous read for the display path.
module sprite_line_buffer #(
  parameter int DEPTH = 64,
  parameter int AW    = 6,
  parameter int DW    = 12
) (
  input  logic          i_pclk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [DEPTH];

  always_ff @(posedge i_pclk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sprite_line_fetch.sv
// Fetches the next line's sprite row from the image ROM during hblank and
// overlays it on the background stream with a fixed one-cycle latency.
module sprite_line_fetch
  import vga_pkg::*;
#(
  parameter int          SPRITE_W    = 64,
  parameter int          SPRITE_H    = 64,
  parameter int          ROM_LAT     = 2,
  parameter int          ADDR_W      = 12,
  parameter int          V_TOTAL     = V_TOTAL_LINES,
  parameter logic [11:0] TRANSPARENT = TRANSPARENT_RGB
) (
  input  logic              pclk,
  input  logic              rst,
  input  logic [10:0]       hcount_in,
  input  logic [10:0]       vcount_in,
  input  logic              hblnk_in,
  input  logic              vblnk_in,
  input  logic              hs_in,
  input  logic              vs_in,
  input  logic [11:0]       rgb_in,
  input  logic [11:0]       xpos,
  input  logic [11:0]       ypos,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [11:0]       rom_data,
  output logic [10:0]       hcount,
  output logic [10:0]       vcount,
  output logic              hblnk,
  output logic              vblnk,
  output logic              hs_out,
  output logic              vs_out,
  output logic [11:0]       rgb_out,
  output logic              busy,
  output logic              overrun,
  output logic [1:0]        fsm_state
);

  localparam int COL_W = $clog2(SPRITE_W);
  localparam int LAT_W = $clog2(ROM_LAT + 1);

  fetch_state_t      r_state, w_state_next;
  logic [COL_W-1:0]  r_col;
  logic [ADDR_W-1:0] r_base;
  logic [LAT_W-1:0]  r_lat_cnt;
  logic              r_line_valid;
  logic [11:0]       r_x_lat, r_y_lat;
  logic [ROM_LAT:0]  r_we_pipe;
  logic [COL_W-1:0]  r_col_pipe [ROM_LAT+1];

  logic              w_hblnk_rise, w_hblnk_fall, w_vblnk_rise;
  logic [11:0]       w_next12;
  logic [12:0]       w_next13, w_y13, w_row13, w_h13, w_x13;
  logic              w_in_rows, w_in_cols, w_show;
  logic              w_start, w_abort, w_issue;
  logic [COL_W-1:0]  w_rd_addr;
  logic [11:0]       w_pix;

  // The registered timing outputs double as the previous-sample edge detectors.
  assign w_hblnk_rise = hblnk_in & ~hblnk;
  assign w_hblnk_fall = ~hblnk_in & hblnk;
  assign w_vblnk_rise = vblnk_in & ~vblnk;

  assign w_next12  = (vcount_in == 11'(V_TOTAL - 1)) ? 12'd0 : {1'b0, vcount_in} + 12'd1;
  assign w_next13  = {1'b0, w_next12};
  assign w_y13     = {1'b0, r_y_lat};
  assign w_in_rows = (w_next13 >= w_y13) && (w_next13 < w_y13 + 13'(SPRITE_H));
  assign w_row13   = w_next13 - w_y13;

  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_abort      = 1'b0;
    w_issue      = 1'b0;
    unique case (r_state)
      IDLE, READY: begin
        if (w_hblnk_rise) begin
          if (w_in_rows) begin
            w_state_next = FETCH;
            w_start      = 1'b1;
          end else begin
            w_state_next = IDLE;
          end
        end
      end
      FETCH: begin
        if (w_hblnk_fall) begin
          w_abort      = 1'b1;
          w_state_next = IDLE;
        end else begin
          w_issue = 1'b1;
          if (r_col == COL_W'(SPRITE_W - 1)) w_state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (w_hblnk_fall) begin
          w_abort      = 1'b1;
          w_state_next = IDLE;
        end else if (r_lat_cnt == LAT_W'(ROM_LAT - 1)) begin
          w_state_next = READY;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_col        <= '0;
      r_base       <= '0;
      r_lat_cnt    <= '0;
      r_line_valid <= 1'b0;
      r_x_lat      <= '0;
      r_y_lat      <= '0;
      rom_addr     <= '0;
      overrun      <= 1'b0;
    end else begin
      r_state <= w_state_next;
      overrun <= w_abort;
      if (w_vblnk_rise) begin
        r_x_lat <= xpos;
        r_y_lat <= ypos;
      end
      if (w_start) begin
        r_col  <= '0;
        r_base <= ADDR_W'({w_row13, {COL_W{1'b0}}});
      end else if (w_issue) begin
        rom_addr <= r_base | ADDR_W'(r_col);
        r_col    <= r_col + 1'b1;
      end
      if (r_state == DRAIN) r_lat_cnt <= r_lat_cnt + 1'b1;
      else                  r_lat_cnt <= '0;
      if (w_abort || w_hblnk_rise) r_line_valid <= 1'b0;
      else if (r_state == READY)   r_line_valid <= 1'b1;
    end
  end

  // Write strobe and column travel alongside the ROM so each word lands in its own slot.
  always_ff @(posedge pclk) begin
    if (rst) begin
      r_we_pipe <= '0;
      for (int i = 0; i <= ROM_LAT; i++) r_col_pipe[i] <= '0;
    end else begin
      r_we_pipe     <= {r_we_pipe[ROM_LAT-1:0], w_issue};
      r_col_pipe[0] <= r_col;
      for (int i = 1; i <= ROM_LAT; i++) r_col_pipe[i] <= r_col_pipe[i-1];
    end
  end

  sprite_line_buffer #(
    .DEPTH(SPRITE_W),
    .AW   (COL_W),
    .DW   (12)
  ) u_line_buffer (
    .i_pclk (pclk),
    .i_we   (r_we_pipe[ROM_LAT]),
    .i_waddr(r_col_pipe[ROM_LAT]),
    .i_wdata(rom_data),
    .i_raddr(w_rd_addr),
    .o_rdata(w_pix)
  );

  assign w_h13     = {2'b00, hcount_in};
  assign w_x13     = {1'b0, r_x_lat};
  assign w_in_cols = (w_h13 >= w_x13) && (w_h13 < w_x13 + 13'(SPRITE_W));
  assign w_rd_addr = COL_W'({1'b0, hcount_in} - r_x_lat);
  assign w_show    = r_line_valid && !hblnk_in && !vblnk_in && w_in_cols && (w_pix != TRANSPARENT);

  always_ff @(posedge pclk) begin
    if (rst) begin
      hcount  <= '0;
      vcount  <= '0;
      hblnk   <= 1'b0;
      vblnk   <= 1'b0;
      hs_out  <= 1'b0;
      vs_out  <= 1'b0;
      rgb_out <= '0;
    end else begin
      hcount  <= hcount_in;
      vcount  <= vcount_in;
      hblnk   <= hblnk_in;
      vblnk   <= vblnk_in;
      hs_out  <= hs_in;
      vs_out  <= vs_in;
      rgb_out <= w_show ? w_pix : rgb_in;
    end
  end

  assign busy      = (r_state == FETCH) || (r_state == DRAIN);
  assign fsm_state = r_state;

endmodule

// File: tb/tb_sprite_line_fetch.sv
// Bench for sprite_line_fetch: compact VGA timing generator, latency-2 ROM
// model, and a behavioural model feeding an expected-output queue.
module tb_sprite_line_fetch;
  import vga_pkg::*;

  localparam int SW       = 64;
  localparam int SH       = 16;
  localparam int LAT      = 2;
  localparam int AW       = 10;
  localparam int VT       = 40;
  localparam int VA       = 36;
  localparam int HA       = 180;
  localparam int HB_LONG  = 90;
  localparam int HB_SHORT = 30;
  localparam int EXP_W    = 39;

  logic          pclk = 1'b0;
  logic          rst = 1'b1;
  logic [10:0]   hcount_in = '0, vcount_in = '0;
  logic          hblnk_in = 1'b0, vblnk_in = 1'b0, hs_in = 1'b0, vs_in = 1'b0;
  logic [11:0]   rgb_in = '0, xpos = 12'd100, ypos = 12'd10;
  logic [AW-1:0] rom_addr;
  logic [11:0]   rom_data;
  logic [10:0]   hcount, vcount;
  logic          hblnk, vblnk, hs_out, vs_out, busy, overrun;
  logic [11:0]   rgb_out;
  logic [1:0]    fsm_state;

  always #5 pclk = ~pclk;

  sprite_line_fetch #(
    .SPRITE_W(SW), .SPRITE_H(SH), .ROM_LAT(LAT), .ADDR_W(AW),
    .V_TOTAL(VT), .TRANSPARENT(12'h000)
  ) dut (
    .pclk(pclk), .rst(rst),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hblnk_in(hblnk_in), .vblnk_in(vblnk_in), .hs_in(hs_in), .vs_in(vs_in),
    .rgb_in(rgb_in), .xpos(xpos), .ypos(ypos),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .hcount(hcount), .vcount(vcount), .hblnk(hblnk), .vblnk(vblnk),
    .hs_out(hs_out), .vs_out(vs_out), .rgb_out(rgb_out),
    .busy(busy), .overrun(overrun), .fsm_state(fsm_state)
  );

  // Image content: the address itself, with column 5 of every row see-through.
  function automatic logic [11:0] rom_fn(input logic [AW-1:0] a);
    return (a[5:0] == 6'd5) ? 12'h000 : {2'b00, a};
  endfunction

  logic [11:0] r_rom1, r_rom2;
  always @(posedge pclk) begin
    r_rom1 <= rom_fn(rom_addr);
    r_rom2 <= r_rom1;
  end
  assign rom_data = r_rom2;

  // Scoreboard and counters
  logic [EXP_W-1:0] exp_q[$];
  logic [AW-1:0]    addr_q[$];
  int n_cmp = 0, n_fail = 0;
  int n_extra = 0, busy_cnt = 0, ovr_cnt = 0, addr_chg = 0;
  logic [AW-1:0] last_addr = '0;
  bit mon_prev_fetch = 0, mon_prev_rst = 0;

  // Timing generator and reference model state
  int h = 50, v = VA - 1, hb_len = HB_LONG;
  int x_lat_m = 0, y_lat_m = 0;
  int pend_line = -1, pend_row = 0, valid_line = -1, valid_row = 0;
  bit prev_h = 0, prev_v = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (line %0d hcount %0d)", tag, got, exp, v, h);
    end
  endtask

  task automatic step(input bit r);
    logic [EXP_W-1:0] e;
    logic             hb, vb, hs, vs, ovr, show;
    logic [11:0]      bg, pix;
    int               nxt;
    @(negedge pclk);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("timing", {hcount, vcount, hblnk, vblnk, hs_out, vs_out}, e[38:13]);
      check("rgb_out", rgb_out, e[12:1]);
      check("overrun", overrun, e[0]);
    end
    if (mon_prev_rst) begin
      check("rst_busy", busy, 0);
      check("rst_addr", rom_addr, 0);
    end
    if (mon_prev_fetch) begin
      if (addr_q.size() > 0) check("rom_addr", rom_addr, addr_q.pop_front());
      else n_extra++;
    end
    if (busy) busy_cnt++;
    if (overrun) ovr_cnt++;
    if (rom_addr !== last_addr) addr_chg++;
    last_addr      = rom_addr;
    mon_prev_fetch = (fsm_state == FETCH) && !r && (hb_len >= HB_LONG);
    mon_prev_rst   = r;

    hb = (h >= HA);
    vb = (v >= VA);
    hs = (h >= HA + 10) && (h < HA + 20);
    vs = (v == VA + 1) || (v == VA + 2);
    bg = 12'($urandom_range(0, 4095));
    rst = r;
    hcount_in = 11'(h); vcount_in = 11'(v);
    hblnk_in = hb; vblnk_in = vb; hs_in = hs; vs_in = vs; rgb_in = bg;

    ovr = 1'b0;
    if (r) begin
      x_lat_m = 0; y_lat_m = 0;
      pend_line = -1; valid_line = -1;
      prev_h = 0; prev_v = 0;
      addr_q.delete();
      e = '0;
    end else begin
      if (vb && !prev_v) begin
        x_lat_m = int'(xpos);
        y_lat_m = int'(ypos);
      end
      if (hb && !prev_h) begin
        nxt = (v == VT - 1) ? 0 : v + 1;
        valid_line = -1;
        pend_line  = -1;
        if (nxt >= y_lat_m && nxt < y_lat_m + SH) begin
          pend_line = nxt;
          pend_row  = nxt - y_lat_m;
          if (hb_len >= HB_LONG)
            for (int c = 0; c < SW; c++) addr_q.push_back(AW'(pend_row * SW + c));
        end
      end
      if (!hb && prev_h) begin
        if (pend_line >= 0) begin
          if (hb_len >= HB_LONG) begin
            valid_line = pend_line;
            valid_row  = pend_row;
          end else begin
            ovr = 1'b1;
          end
        end
        pend_line = -1;
        check("addr_left", addr_q.size(), 0);
      end
      pix  = bg;
      show = (valid_line == v) && !hb && !vb && (h >= x_lat_m) && (h < x_lat_m + SW);
      if (show) begin
        pix = rom_fn(AW'(valid_row * SW + (h - x_lat_m)));
        if (pix == 12'h000) pix = bg;
      end
      e = {11'(h), 11'(v), hb, vb, hs, vs, pix, ovr};
      prev_h = hb;
      prev_v = vb;
    end
    exp_q.push_back(e);

    h++;
    if (h == HA + hb_len) begin
      h = 0;
      v = (v == VT - 1) ? 0 : v + 1;
    end
  endtask

  task automatic run_to(input int tv, input int th);
    for (int i = 0; i < 20000; i++) begin
      if (v == tv && h == th) break;
      step(1'b0);
    end
  endtask

  int busy_base, chg_base, ovr_base;

  initial begin
    // Reset held mid-line, then one frame at (100,10) with a mid-frame move
    repeat (5) step(1'b1);
    run_to(20, 0);
    xpos = 12'd150;
    ypos = 12'd0;

    // Next frame at (150,0): line 0 fetched across the frame wrap; reset mid-fetch on line 5
    run_to(5, HA + 40);
    repeat (HB_LONG - 40 + 5) step(1'b1);
    run_to(20, 0);
    xpos = 12'd100;
    ypos = 12'd300;

    // Sprite entirely below the frame: no fetch activity at all
    run_to(0, 0);
    busy_base = busy_cnt;
    chg_base  = addr_chg;
    run_to(20, 0);
    check("idle_busy_cycles", busy_cnt - busy_base, 0);
    check("idle_addr_changes", addr_chg - chg_base, 0);
    xpos = 12'd100;
    ypos = 12'd10;

    // Hblank too short for a full row: every sprite line aborts once
    run_to(0, 0);
    hb_len   = HB_SHORT;
    ovr_base = ovr_cnt;
    run_to(30, 0);
    check("overrun_pulses", ovr_cnt - ovr_base, SH);
    hb_len = HB_LONG;

    // Recovery with normal hblank
    run_to(12, 0);
    step(1'b0);
    check("addr_extra", n_extra, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
